updown_mod_counter: RTL

- Parametrised successor to the team's basic load/enable counter: adds up/down direction, programmable modulus, step size, terminal-count and wrap flags.
- Used as a general timebase, divider or index generator in the IEEE silicon demo designs and their successors.
- Single clock domain; all state is registered.

---
 rtl/updown_mod_counter_pkg.sv | 18 +
 rtl/mod_step_calc.sv | 69 ++++++
 rtl/updown_mod_counter.sv | 130 +++++++++++++
 3 files changed

// File: rtl/updown_mod_counter_pkg.sv
// rtl/updown_mod_counter_pkg.sv - default sizes, direction codes and per-edge op priority for updown_mod_counter
package updown_mod_counter_pkg;

  localparam int LEN_DEF    = 4;
  localparam int STEP_W_DEF = 2;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  // Enumerated highest priority first; exactly one op is resolved per edge.
  typedef enum logic [1:0] {
    OP_CLR,
    OP_LOAD,
    OP_COUNT,
    OP_HOLD
  } op_e;

endpackage

// File: rtl/mod_step_calc.sv
// rtl/mod_step_calc.sv - combinational next-count, wrap and terminal-count calculator for updown_mod_counter
module mod_step_calc
  import updown_mod_counter_pkg::*;
#(
  parameter int len    = LEN_DEF,
  parameter int MOD    = 2**len,
  parameter int STEP_W = STEP_W_DEF
) (
  input  logic [len-1:0]    cur,
  input  logic [STEP_W-1:0] step,
  input  logic              up_dn,
  input  logic              sat_mode,
  input  logic              c_en,
  output logic [len-1:0]    next,
  output logic              wrap_n,
  output logic              clamp_n,
  output logic              tc
);

  // One extra bit so cur+step and cur+MOD never overflow when MOD == 2**len.
  localparam logic [len:0] MOD_W = (len+1)'(MOD);
  localparam logic [len:0] MAX_E = (len+1)'(MOD-1);

  logic [len:0] cur_e;
  logic [len:0] step_e;
  logic [len:0] sum_e;

  assign cur_e  = {1'b0, cur};
  assign step_e = (len+1)'(step);
  assign sum_e  = cur_e + step_e;

  always_comb begin
    next    = cur;
    wrap_n  = 1'b0;
    clamp_n = 1'b0;
    case (up_dn)
      DIR_UP: begin
        if (sum_e >= MOD_W) begin
          if (sat_mode) begin
            next    = len'(MAX_E);
            clamp_n = 1'b1;
          end else begin
            next   = len'(sum_e - MOD_W);
            wrap_n = 1'b1;
          end
        end else begin
          next = len'(sum_e);
        end
      end
      DIR_DN: begin
        if (step_e > cur_e) begin
          if (sat_mode) begin
            next    = '0;
            clamp_n = 1'b1;
          end else begin
            next   = len'(cur_e + MOD_W - step_e);
            wrap_n = 1'b1;
          end
        end else begin
          next = len'(cur_e - step_e);
        end
      end
      default: ;
    endcase
  end

  assign tc = c_en & (step != '0) & (wrap_n | clamp_n);

endmodule

// File: rtl/updown_mod_counter.sv
// rtl/updown_mod_counter.sv - up/down modulo counter with load, clear, step and wrap flag; saturation via COUNTER_SAT_EN
module updown_mod_counter
  import updown_mod_counter_pkg::*;
#(
  parameter int len    = LEN_DEF,
  parameter int MOD    = 2**len,
  parameter int STEP_W = STEP_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_clr,
  input  logic              p_load,
  input  logic [len-1:0]    p_load_data,
  input  logic              c_en,
  input  logic              up_dn,
  input  logic [STEP_W-1:0] step,
`ifdef COUNTER_SAT_EN
  input  logic              sat_mode,
  output logic              sat,
`endif
  output logic [len-1:0]    out,
  output logic              tc,
  output logic              wrap
);

  localparam logic [len:0]   MOD_W = (len+1)'(MOD);
  localparam logic [len-1:0] MAX_V = len'(MOD-1);

  op_e            op;
  logic [len-1:0] out_d, out_q;
  logic           wrap_d, wrap_q;
  logic [len-1:0] next_v;
  logic           wrap_n;
  logic           clamp_n;
  logic           sat_mode_i;

`ifdef COUNTER_SAT_EN
  logic           sat_d, sat_q;
  assign sat_mode_i = sat_mode;
`else
  logic           unused_clamp;
  assign sat_mode_i   = 1'b0;
  assign unused_clamp = clamp_n;
`endif

  mod_step_calc #(
    .len    (len),
    .MOD    (MOD),
    .STEP_W (STEP_W)
  ) u_calc (
    .cur      (out_q),
    .step     (step),
    .up_dn    (up_dn),
    .sat_mode (sat_mode_i),
    .c_en     (c_en),
    .next     (next_v),
    .wrap_n   (wrap_n),
    .clamp_n  (clamp_n),
    .tc       (tc)
  );

  always_comb begin
    op = OP_HOLD;
    if (s_clr)       op = OP_CLR;
    else if (p_load) op = OP_LOAD;
    else if (c_en)   op = OP_COUNT;
  end

  always_comb begin
    out_d  = out_q;
    wrap_d = 1'b0;
`ifdef COUNTER_SAT_EN
    sat_d  = sat_q;
`endif
    case (op)
      OP_CLR: begin
        out_d = '0;
`ifdef COUNTER_SAT_EN
        sat_d = 1'b0;
`endif
      end
      OP_LOAD: begin
        out_d = ({1'b0, p_load_data} < MOD_W) ? p_load_data : MAX_V;
`ifdef COUNTER_SAT_EN
        sat_d = 1'b0;
`endif
      end
      OP_COUNT: begin
        // A zero step is a hold: sat keeps its level.
        if (step != '0) begin
          out_d  = next_v;
          wrap_d = wrap_n;
`ifdef COUNTER_SAT_EN
          sat_d  = clamp_n;
`endif
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_q  <= '0;
      wrap_q <= 1'b0;
`ifdef COUNTER_SAT_EN
      sat_q  <= 1'b0;
`endif
    end else begin
      out_q  <= out_d;
      wrap_q <= wrap_d;
`ifdef COUNTER_SAT_EN
      sat_q  <= sat_d;
`endif
    end
  end

  assign out  = out_q;
  assign wrap = wrap_q;
`ifdef COUNTER_SAT_EN
  assign sat  = sat_q;
`endif

`ifndef SYNTHESIS
  // Only a single modular correction is implemented, so steps at or above MOD are illegal.
  step_legal_a: assert property (@(posedge clk) disable iff (!reset)
    (c_en && !s_clr && !p_load) |-> (32'(step) < MOD));
`endif

endmodule
